// File: rtl/smc_rd_strobe_lite.sv
// smc_rd_strobe_lite: read strobe sequencer and lane-masked data capture for the lite SMC
// Ports:
//   hclk, sys_reset             clock, asynchronous active-high reset
//   rd_req, rd_be               read request pulse and byte lanes (sampled at accept)
//   r_oe_dly, r_wait_rd, r_turn setup, extra strobe and turnaround cycles (sampled at accept)
//   smc_data_in                 external data bus
//   smc_n_rd, smc_n_oe, smc_n_be active-low chip strobe, output enable, byte lanes
//   rd_data, rd_valid, rd_busy  captured data, one-cycle update pulse, FSM not idle
module smc_rd_strobe_lite #(
  parameter int DW   = 32,
  parameter int WS_W = 4
) (
  input  logic            hclk,
  input  logic            sys_reset,
  input  logic            rd_req,
  input  logic [3:0]      rd_be,
  input  logic [WS_W-1:0] r_oe_dly,
  input  logic [WS_W-1:0] r_wait_rd,
  input  logic [1:0]      r_turn,
  input  logic [DW-1:0]   smc_data_in,
  output logic            smc_n_rd,
  output logic            smc_n_oe,
  output logic [3:0]      smc_n_be,
  output logic [DW-1:0]   rd_data,
  output logic            rd_valid,
  output logic            rd_busy
);
  localparam int L = DW / 4;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, TURN} state_t;
  state_t          state_q, state_d;
  logic [WS_W-1:0] cnt_q, cnt_d, wait_q, wait_d;
  logic [1:0]      turn_q, turn_d;
  logic [3:0]      be_q, be_d;
  logic [DW-1:0]   mask;
  logic            last, active_d;
  // last strobe cycle: data is sampled on the edge that ends it
  assign last     = state_q == STROBE && cnt_q == '0;
  assign active_d = state_d == SETUP || state_d == STROBE;
  always_comb begin
    mask = '0;
    for (int i = 0; i < 4; i++) mask[i*L +: L] = {L{be_q[i]}};
  end
  // counters only load and count down to zero, so maximum settings never wrap
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    turn_d  = turn_q;
    be_d    = be_q;
    if (state_q == IDLE && rd_req) begin
      be_d    = rd_be;
      wait_d  = r_wait_rd;
      turn_d  = r_turn;
      state_d = r_oe_dly != '0 ? SETUP : STROBE;
      cnt_d   = r_oe_dly != '0 ? r_oe_dly - WS_W'(1) : r_wait_rd;
    end else if (state_q == SETUP) begin
      state_d = cnt_q == '0 ? STROBE : SETUP;
      cnt_d   = cnt_q == '0 ? wait_q : cnt_q - WS_W'(1);
    end else if (state_q == STROBE) begin
      state_d = !last ? STROBE : turn_q != '0 ? TURN : IDLE;
      cnt_d   = !last ? cnt_q - WS_W'(1) : turn_q != '0 ? WS_W'(turn_q - 2'd1) : '0;
    end else if (state_q == TURN) begin
      state_d = cnt_q == '0 ? IDLE : TURN;
      cnt_d   = cnt_q == '0 ? '0 : cnt_q - WS_W'(1);
    end
  end
  // strobes are decoded from the next state and registered, so they are glitch-free
  always_ff @(posedge hclk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wait_q   <= '0;
      turn_q   <= '0;
      be_q     <= '0;
      smc_n_rd <= 1'b1;
      smc_n_oe <= 1'b1;
      smc_n_be <= 4'hF;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_busy  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      turn_q   <= turn_d;
      be_q     <= be_d;
      smc_n_rd <= !active_d;
      smc_n_oe <= state_d != STROBE;
      smc_n_be <= active_d ? ~be_d : 4'hF;
      rd_data  <= last ? smc_data_in & mask : rd_data;
      rd_valid <= last;
      rd_busy  <= state_d != IDLE;
    end
  end
endmodule
